// File: rtl/alu_seq_if.sv
// alu_seq_if: start/busy/done handshake plus operand and result bus for alu_seq.
// master = controller side (drives request), slave = ALU side (drives result).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operanda;
    logic [WIDTH-1:0] operandb;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             err;
    logic             busy;
    logic             done;

    modport master (
        output start, op, operanda, operandb,
        input  result, carry, zero, err, busy, done
    );

    modport slave (
        input  start, op, operanda, operandb,
        output result, carry, zero, err, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake.
// Ops: ADD, SUB, SETLO, SETHI, CLR, iterative SHL/SHR, optional iterative MUL.
// Build option: define ALU_MUL_EN to include the shift-add multiplier; without
// it op 111 completes in one cycle with err set and a zero result.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic     clk,
    input logic     reset_n,
    alu_seq_if.slave bus
);
    localparam int HALF = WIDTH / 2;
    localparam int SHW  = $clog2(WIDTH);
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_SETLO = 3'b010;
    localparam logic [2:0] OP_SETHI = 3'b011;
    localparam logic [2:0] OP_CLR   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    typedef enum logic {IDLE, EXEC} state_t;

    // Control and architectural outputs (reset)
    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    // Latched operands and iteration state (datapath, no reset needed)
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   mul_sum;
`endif

    logic [WIDTH:0]   add_sum;
    logic             fin;
    logic [WIDTH-1:0] res_n;
    logic             cy_n;
    logic             err_n;

    assign add_sum = {1'b0, a_q} + {1'b0, b_q};

`ifdef ALU_MUL_EN
    // One shift-add step: add multiplicand into the high half when the current
    // multiplier bit (LSB of work) is set; the sum's LSB shifts into work.
    assign mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, a_q} : '0);
`endif

    // Next-state, operand latching and completion logic
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
`endif
        fin      = 1'b0;
        res_n    = '0;
        cy_n     = 1'b0;
        err_n    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.operanda;
                    b_d     = bus.operandb;
                    busy_d  = 1'b1;
                    state_d = EXEC;
                    case (bus.op)
                        OP_SHL, OP_SHR: begin
                            work_d = bus.operanda;
                            cnt_d  = CW'(bus.operandb[SHW-1:0]);
                        end
                        OP_MUL: begin
                            work_d = bus.operandb;
                            cnt_d  = CW'(WIDTH);
`ifdef ALU_MUL_EN
                            acc_d  = '0;
`endif
                        end
                        default: begin
                            cnt_d = CW'(1);
                        end
                    endcase
                end
            end

            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        fin   = 1'b1;
                        res_n = add_sum[WIDTH-1:0];
                        cy_n  = add_sum[WIDTH];
                    end
                    OP_SUB: begin
                        fin   = 1'b1;
                        res_n = a_q - b_q;
                        cy_n  = (a_q < b_q);
                    end
                    OP_SETLO: begin
                        fin   = 1'b1;
                        res_n = {a_q[WIDTH-1:HALF], b_q[HALF-1:0]};
                    end
                    OP_SETHI: begin
                        fin   = 1'b1;
                        res_n = {b_q[HALF-1:0], a_q[HALF-1:0]};
                    end
                    OP_CLR: begin
                        fin   = 1'b1;
                    end
                    OP_SHL: begin
                        if (cnt_q == '0) begin
                            fin   = 1'b1;
                            res_n = work_q;
                        end else begin
                            work_d = work_q << 1;
                            cnt_d  = cnt_q - CW'(1);
                            if (cnt_q == CW'(1)) begin
                                fin   = 1'b1;
                                res_n = work_q << 1;
                                cy_n  = work_q[WIDTH-1];
                            end
                        end
                    end
                    OP_SHR: begin
                        if (cnt_q == '0) begin
                            fin   = 1'b1;
                            res_n = work_q;
                        end else begin
                            work_d = work_q >> 1;
                            cnt_d  = cnt_q - CW'(1);
                            if (cnt_q == CW'(1)) begin
                                fin   = 1'b1;
                                res_n = work_q >> 1;
                                cy_n  = work_q[0];
                            end
                        end
                    end
                    default: begin
`ifdef ALU_MUL_EN
                        acc_d  = mul_sum[WIDTH:1];
                        work_d = {mul_sum[0], work_q[WIDTH-1:1]};
                        cnt_d  = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            fin   = 1'b1;
                            res_n = {mul_sum[0], work_q[WIDTH-1:1]};
                            cy_n  = |mul_sum[WIDTH:1];
                        end
`else
                        fin   = 1'b1;
                        err_n = 1'b1;
`endif
                    end
                endcase

                if (fin) begin
                    result_d = res_n;
                    carry_d  = cy_n;
                    zero_d   = (res_n == '0);
                    err_d    = err_n;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    // Datapath registers; only read in EXEC after being loaded in IDLE
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        a_q    <= a_d;
        b_q    <= b_d;
        work_q <= work_d;
        cnt_q  <= cnt_d;
`ifdef ALU_MUL_EN
        acc_q  <= acc_d;
`endif
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (works with or without ALU_MUL_EN).
module tb_alu_seq;
    localparam int W   = 8;
    localparam int H   = W / 2;
    localparam int SHW = $clog2(W);

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         zr;
        logic         er;
        int           lat;
        int           k;
    } exp_t;

    exp_t sb[$];
    logic done_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference behaviour of each op
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic e, output int lat);
        int n;
        logic [2*W-1:0] p;
        logic [W:0] s;
        n = int'(b[SHW-1:0]);
        r = '0; c = 1'b0; e = 1'b0; lat = 1;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = {a[W-1:H], b[H-1:0]};
            3'd3: r = {b[H-1:0], a[H-1:0]};
            3'd4: r = '0;
            3'd5: if (n == 0) r = a; else begin r = a << n; c = a[W-n]; lat = n; end
            3'd6: if (n == 0) r = a; else begin r = a >> n; c = a[n-1]; lat = n; end
            default: begin
`ifdef ALU_MUL_EN
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = p[W-1:0]; c = |p[2*W-1:W]; lat = W;
`else
                p = '0; e = 1'b1;
`endif
            end
        endcase
    endtask

    // Drive one request from a negedge; returns just after the sampling edge
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t x;
        bus.start = 1'b1; bus.op = op; bus.operanda = a; bus.operandb = b;
        model(op, a, b, x.res, x.cy, x.er, x.lat);
        x.zr = (x.res == '0);
        @(posedge clk); #1;
        x.k = cyc;
        sb.push_back(x);
        bus.start = 1'b0;
        bus.operanda = W'($urandom);
        bus.operandb = W'($urandom);
        bus.op = 3'($urandom);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("done_timeout", 64'(guard >= 40), 64'd0);
    endtask

    // Monitor: compare completions against the scoreboard, check handshake
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.done) begin
                check("done_pulse", 64'(done_prev), 64'd0);
                check("busy_at_done", 64'(bus.busy), 64'd0);
                if (sb.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("result", 64'(bus.result), 64'(x.res));
                    check("carry", 64'(bus.carry), 64'(x.cy));
                    check("zero", 64'(bus.zero), 64'(x.zr));
                    check("err", 64'(bus.err), 64'(x.er));
                    check("latency", 64'(cyc - x.k), 64'(x.lat));
                end
            end else if (sb.size() > 0) begin
                check("busy", 64'(bus.busy), 64'd1);
            end
            done_prev <= bus.done;
        end else begin
            done_prev <= 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, 64'(bus.result), 64'd0);
        check({tag, "_carry"}, 64'(bus.carry), 64'd0);
        check({tag, "_zero"}, 64'(bus.zero), 64'd1);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0; done_prev = 1'b0;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.operanda = '0; bus.operandb = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");

        // Test-plan vectors, anchored with literal values as well as the model
        issue(3'd0, 8'hF0, 8'h20); wait_done();
        check("add_lit", 64'({bus.carry, bus.result}), 64'h110);
        issue(3'd1, 8'h05, 8'h07); wait_done();
        check("sub_lit", 64'({bus.carry, bus.result}), 64'h1FE);
        issue(3'd1, 8'h33, 8'h33); wait_done();
        issue(3'd2, 8'hAB, 8'h3C); wait_done();
        check("setlo_lit", 64'(bus.result), 64'hAC);
        issue(3'd3, 8'hAB, 8'h3C); wait_done();
        check("sethi_lit", 64'(bus.result), 64'hCB);
        issue(3'd4, 8'h5A, 8'hA5); wait_done();

        // Shift with a second start pulsed mid-operation (must be ignored)
        issue(3'd5, 8'h81, 8'd3);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.operanda = 8'h01; bus.operandb = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        check("shl_lit", 64'({bus.carry, bus.result}), 64'h008);
        repeat (3) @(negedge clk);
        issue(3'd6, 8'h81, 8'd1); wait_done();
        check("shr_lit", 64'({bus.carry, bus.result}), 64'h140);
        issue(3'd5, 8'h81, 8'd0); wait_done();
        issue(3'd6, 8'hFF, 8'd7); wait_done();

        // Multiply (or unsupported op)
        issue(3'd7, 8'h12, 8'h0D); wait_done();
`ifdef ALU_MUL_EN
        check("mul_lit", 64'({bus.carry, bus.result}), 64'h0EA);
`else
        check("mul_err_lit", 64'({bus.err, bus.result}), 64'h100);
`endif
        issue(3'd7, 8'h10, 8'h10); wait_done();

        // Back-to-back: issue on the negedge where done is high
        issue(3'd0, 8'hFF, 8'h01); wait_done();
        issue(3'd1, 8'h00, 8'h01); wait_done();

        // Random mix
        for (int i = 0; i < 24; i++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            wait_done();
        end

        // Reset in the middle of a long operation
`ifdef ALU_MUL_EN
        issue(3'd7, 8'hFF, 8'hFF);
`else
        issue(3'd5, 8'hFF, 8'd7);
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        sb.delete();
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_no_done", 64'(bus.done), 64'd0);
        end
        issue(3'd0, 8'h12, 8'h34); wait_done();
        check("post_rst_add", 64'(bus.result), 64'h46);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
